// File: rtl/bht_sat_gshare.sv
`default_nettype none
// ============================================================================
//  Module      : bht_sat_gshare
//  Description : Branch history table of saturating counters with bimodal or
//                gshare indexing, registered prediction, execute-side training
//                port and a sequential one-entry-per-cycle flush engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module bht_sat_gshare #(
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int PC_BITS   = 9,
    parameter int GHR_BITS  = 4,
    parameter int MODE      = 0,
    localparam int ADDR_BITS = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lookup_valid,
    input  logic [PC_BITS-1:0]   lookup_pc,
    output logic                 pred_valid,
    output logic                 prediction,
    output logic [ADDR_BITS-1:0] pred_index,
    input  logic                 update_valid,
    input  logic [ADDR_BITS-1:0] update_index,
    input  logic                 update_taken,
    input  logic                 flush,
    output logic                 busy
);

    // Weakly not-taken reset value, all-ones saturation ceiling, last entry.
    localparam logic [CTR_BITS-1:0]  c_init = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0]  c_max  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]  c_zero = '0;
    localparam logic [ADDR_BITS-1:0] c_last = ADDR_BITS'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_busy;
    logic [ADDR_BITS-1:0]  r_ptr;
    logic [GHR_BITS-1:0]   r_ghr;
    logic [GHR_BITS-1:0]   w_ghr_shift;
    logic [CTR_BITS-1:0]   r_table [ENTRIES];
    logic [CTR_BITS-1:0]   w_ctr_cur;
    logic [CTR_BITS-1:0]   w_ctr_next;
    logic [ADDR_BITS-1:0]  w_lookup_idx;
    logic                  r_pred_valid;
    logic                  r_prediction;
    logic [ADDR_BITS-1:0]  r_pred_index;
    logic                  w_idle;
    logic                  w_start_flush;
    logic                  w_do_lookup;
    logic                  w_do_update;
    logic                  w_unused_pc;

    // A flush request in IDLE beats any same-cycle lookup or update.
    assign w_idle        = (r_state == ST_IDLE);
    assign w_start_flush = w_idle & flush;
    assign w_do_lookup   = w_idle & ~flush & lookup_valid;
    assign w_do_update   = w_idle & ~flush & update_valid;

    // PC bits above the index are deliberately ignored.
    assign w_unused_pc = ^lookup_pc;

    generate
        if (MODE == 1) begin : g_gshare
            assign w_lookup_idx = lookup_pc[ADDR_BITS-1:0] ^ ADDR_BITS'(r_ghr);
        end else begin : g_bimodal
            assign w_lookup_idx = lookup_pc[ADDR_BITS-1:0];
        end
    endgenerate

    generate
        if (GHR_BITS == 1) begin : g_ghr_single
            assign w_ghr_shift = update_taken;
        end else begin : g_ghr_multi
            assign w_ghr_shift = {r_ghr[GHR_BITS-2:0], update_taken};
        end
    endgenerate

    // Saturating increment/decrement of the counter being trained.
    always_comb begin
        w_ctr_cur  = r_table[update_index];
        w_ctr_next = w_ctr_cur;
        if (update_taken) begin
            if (w_ctr_cur != c_max) begin
                w_ctr_next = w_ctr_cur + 1'b1;
            end
        end else begin
            if (w_ctr_cur != c_zero) begin
                w_ctr_next = w_ctr_cur - 1'b1;
            end
        end
    end

    // Flush sequencing: enter on request, leave after the last entry is written.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (flush) w_state_next = ST_FLUSH;
            ST_FLUSH: if (r_ptr == c_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register; busy is a flopped copy of being in the flush state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_FLUSH);
        end
    end

    // Sweep pointer and global history register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
            r_ghr <= '0;
        end else if (w_start_flush) begin
            r_ptr <= '0;
            r_ghr <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_ptr <= r_ptr + 1'b1;
        end else if (w_do_update) begin
            r_ghr <= w_ghr_shift;
        end
    end

    // Counter table: flush sweep write or resolved-branch training.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= c_init;
            end
        end else if (r_state == ST_FLUSH) begin
            r_table[r_ptr] <= c_init;
        end else if (w_do_update) begin
            r_table[update_index] <= w_ctr_next;
        end
    end

    // Registered prediction, read before any same-cycle training write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pred_valid <= 1'b0;
            r_prediction <= 1'b0;
            r_pred_index <= '0;
        end else begin
            r_pred_valid <= w_do_lookup;
            if (w_do_lookup) begin
                r_prediction <= r_table[w_lookup_idx][CTR_BITS-1];
                r_pred_index <= w_lookup_idx;
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign prediction = r_prediction;
    assign pred_index = r_pred_index;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bht_sat_gshare.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bht_sat_gshare
//  Description : Self-checking bench for bht_sat_gshare; a bimodal and a
//                gshare instance share stimulus and are checked against a
//                table/history model every cycle plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bht_sat_gshare;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lookup_valid = 1'b0;
    logic [8:0] lookup_pc = '0;
    logic       update_valid = 1'b0;
    logic [3:0] update_index = '0;
    logic       update_taken = 1'b0;
    logic       flush = 1'b0;

    logic       pv0, pr0, bz0, pv1, pr1, bz1;
    logic [3:0] pi0, pi1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bht_sat_gshare #(.ENTRIES(16), .CTR_BITS(2), .PC_BITS(9), .GHR_BITS(4), .MODE(0)) u_bimodal (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pv0), .prediction(pr0), .pred_index(pi0),
        .update_valid(update_valid), .update_index(update_index), .update_taken(update_taken),
        .flush(flush), .busy(bz0)
    );

    bht_sat_gshare #(.ENTRIES(16), .CTR_BITS(2), .PC_BITS(9), .GHR_BITS(4), .MODE(1)) u_gshare (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pv1), .prediction(pr1), .pred_index(pi1),
        .update_valid(update_valid), .update_index(update_index), .update_taken(update_taken),
        .flush(flush), .busy(bz1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = bimodal, 1 = gshare) ----
    localparam int INIT = 1;
    int m_tbl [2][16];
    int m_ghr [2];
    int m_pv [2];
    int m_pred [2];
    int m_pidx [2];
    int m_flush_left = 0;

    function automatic int idx_of(input int mode, input int pc, input int ghr);
        return (mode == 1) ? ((pc ^ ghr) % 16) : (pc % 16);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int e = 0; e < 16; e++) m_tbl[m][e] = INIT;
            m_ghr[m] = 0; m_pv[m] = 0; m_pred[m] = 0; m_pidx[m] = 0;
        end
        m_flush_left = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        int li;
        if (!reset) begin
            model_reset();
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            for (int m = 0; m < 2; m++) m_pv[m] = 0;
        end else if (flush) begin
            for (int m = 0; m < 2; m++) begin
                for (int e = 0; e < 16; e++) m_tbl[m][e] = INIT;
                m_ghr[m] = 0;
                m_pv[m] = 0;
            end
            m_flush_left = 16;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (lookup_valid) begin
                    li = idx_of(m, int'(lookup_pc), m_ghr[m]);
                    m_pv[m] = 1;
                    m_pred[m] = (m_tbl[m][li] >= 2) ? 1 : 0;
                    m_pidx[m] = li;
                end else begin
                    m_pv[m] = 0;
                end
                if (update_valid) begin
                    li = int'(update_index);
                    if (update_taken) m_tbl[m][li] = (m_tbl[m][li] < 3) ? m_tbl[m][li] + 1 : 3;
                    else              m_tbl[m][li] = (m_tbl[m][li] > 0) ? m_tbl[m][li] - 1 : 0;
                    m_ghr[m] = ((m_ghr[m] * 2) + (update_taken ? 1 : 0)) % 16;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_bimodal", bz0, (m_flush_left > 0) ? 1 : 0);
            check("busy_gshare", bz1, (m_flush_left > 0) ? 1 : 0);
            check("pv_bimodal", pv0, m_pv[0]);
            check("pv_gshare", pv1, m_pv[1]);
            check("pred_bimodal", pr0, m_pred[0]);
            check("pred_gshare", pr1, m_pred[1]);
            check("pidx_bimodal", pi0, m_pidx[0]);
            check("pidx_gshare", pi1, m_pidx[1]);
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input int idx, input bit taken);
        update_valid = 1'b1; update_index = 4'(idx); update_taken = taken;
        tick();
        update_valid = 1'b0;
    endtask

    task automatic do_lookup(input int pc);
        lookup_valid = 1'b1; lookup_pc = 9'(pc);
        tick();
        lookup_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_pv", pv0, 0);
        check("rst_pred", pr0, 0);
        check("rst_pidx", pi0, 0);
        check("rst_busy", bz0, 0);
        reset = 1'b1;
        tick();

        do_lookup(9'h005);
        check("first_pv", pv0, 1);
        check("first_pred", pr0, 0);
        check("first_pidx", pi0, 5);

        repeat (3) do_update(5, 1'b1);
        do_lookup(9'h015);
        check("sat_hi_pred", pr0, 1);
        check("sat_hi_pidx", pi0, 5);

        repeat (4) do_update(5, 1'b0);
        do_lookup(9'h1F5);
        check("sat_lo_pred", pr0, 0);
        check("hi_pc_ignored", pi0, 5);

        // counter 0 -> 1, then same-cycle lookup and taken update
        do_update(5, 1'b1);
        lookup_valid = 1'b1; lookup_pc = 9'h005;
        update_valid = 1'b1; update_index = 4'd5; update_taken = 1'b1;
        tick();
        lookup_valid = 1'b0; update_valid = 1'b0;
        check("rbw_old_pred", pr0, 0);
        do_lookup(9'h005);
        check("rbw_new_pred", pr0, 1);

        repeat (2) do_update(2, 1'b1);
        do_lookup(9'h002);
        check("idx2_trained", pr0, 1);

        // flush held two cycles; traffic during the window must be dropped
        flush = 1'b1;
        tick();
        check("flush_busy_rise", bz0, 1);
        lookup_valid = 1'b1; lookup_pc = 9'h002;
        update_valid = 1'b1; update_index = 4'd2; update_taken = 1'b0;
        cnt = 0;
        while (bz0 === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 2) flush = 1'b0;
            tick();
        end
        flush = 1'b0; lookup_valid = 1'b0; update_valid = 1'b0;
        check("flush_busy_cycles", cnt, 16);
        check("flush_pv_dropped", pv0, 0);
        do_lookup(9'h002);
        check("post_flush_pred", pr0, 0);
        check("post_flush_ghr0", pi1, 2);

        do_update(0, 1'b1);
        do_update(0, 1'b0);
        do_update(0, 1'b1);
        do_update(0, 1'b1);
        do_lookup(9'h003);
        check("gshare_pidx", pi1, 8);
        check("bimodal_pidx", pi0, 3);

        // train an entry the aborted sweep will not reach, then reset mid-flush
        repeat (2) do_update(7, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        #1 reset = 1'b0;
        #1;
        check("abort_busy_bimodal", bz0, 0);
        check("abort_busy_gshare", bz1, 0);
        check("abort_pv", pv0, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            do_lookup(i);
            check("init_sweep_pred", pr0, 0);
            check("init_sweep_pidx", pi0, i);
        end
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
